// File: rtl/mips_decode_unit.sv
// MIPS instruction decode stage: 32x32 register file with a single write-back
// port, combinational control decode, destination-register selection,
// branch/jump target generation and ALU operation selection.
module mips_decode_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] jr_value,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        wb_en,
  output logic [31:0] rs_val,
  output logic [31:0] rt_val,
  output logic [31:0] rc_val,
  output logic [4:0]  write_reg,
  output logic [31:0] next_addr,
  output logic        link,
  output logic        reg_dst,
  output logic        jump,
  output logic        branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        reg_write,
  output logic        jump_register,
  output logic        sign_or_zero,
  output logic        syscall,
  output logic [5:0]  alu_control
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] branch_off;

  assign opcode     = instr[31:26];
  assign funct      = instr[5:0];
  assign rs_idx     = instr[25:21];
  assign rt_idx     = instr[20:16];
  assign rd_idx     = instr[15:11];
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Next register-file contents: one write-back per cycle, register 0 never written.
  always_comb begin
    for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
    if (wb_en && (wb_reg != 5'd0)) regs_d[wb_reg] = wb_data;
  end

  // Register-file storage; reset clears every entry and blocks writes while low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Raw combinational reads; a same-cycle write is seen only after the edge.
  always_comb begin
    rs_val = (rs_idx    == 5'd0) ? 32'd0 : regs_q[rs_idx];
    rt_val = (rt_idx    == 5'd0) ? 32'd0 : regs_q[rt_idx];
    rc_val = (write_reg == 5'd0) ? 32'd0 : regs_q[write_reg];
  end

  // Control decode: everything defaults low so unknown encodings do nothing.
  always_comb begin
    link          = 1'b0;
    reg_dst       = 1'b0;
    jump          = 1'b0;
    branch        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    alu_src       = 1'b0;
    reg_write     = 1'b0;
    jump_register = 1'b0;
    sign_or_zero  = 1'b0;
    syscall       = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
          6'h26, 6'h27, 6'h2A, 6'h2B: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
          end
          6'h08: begin
            jump          = 1'b1;
            jump_register = 1'b1;
          end
          6'h09: begin
            jump          = 1'b1;
            jump_register = 1'b1;
            link          = 1'b1;
            reg_dst       = 1'b1;
            reg_write     = 1'b1;
          end
          6'h0C: syscall = 1'b1;
          default: ;
        endcase
      end
      6'h01: begin
        case (rt_idx)
          5'h00, 5'h01: begin
            branch       = 1'b1;
            sign_or_zero = 1'b1;
          end
          5'h10, 5'h11: begin
            branch       = 1'b1;
            sign_or_zero = 1'b1;
            link         = 1'b1;
            reg_write    = 1'b1;
          end
          default: ;
        endcase
      end
      6'h02: jump = 1'b1;
      6'h03: begin
        jump      = 1'b1;
        link      = 1'b1;
        reg_write = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        branch       = 1'b1;
        sign_or_zero = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        alu_src      = 1'b1;
        reg_write    = 1'b1;
        sign_or_zero = 1'b1;
      end
      6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h30: begin
        mem_read     = 1'b1;
        alu_src      = 1'b1;
        reg_write    = 1'b1;
        sign_or_zero = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        mem_write    = 1'b1;
        alu_src      = 1'b1;
        sign_or_zero = 1'b1;
      end
      6'h38: begin
        mem_write    = 1'b1;
        alu_src      = 1'b1;
        sign_or_zero = 1'b1;
        reg_write    = 1'b1;
      end
      default: ;
    endcase
  end

  // Destination register, target address and ALU operation selection.
  always_comb begin
    if (reg_dst)   write_reg = rd_idx;
    else if (link) write_reg = 5'd31;
    else           write_reg = rt_idx;

    if (jump && jump_register) next_addr = jr_value;
    else if (jump)             next_addr = {pc_plus4[31:28], instr[25:0], 2'b00};
    else                       next_addr = pc_plus4 + branch_off;

    alu_control = (opcode == 6'h00) ? funct : opcode;
  end

endmodule

// File: tb/tb_mips_decode_unit.sv
// Bench for mips_decode_unit: table of decode vectors plus hand-written
// register-file sequences around write timing and reset.
module tb_mips_decode_unit;

  logic        CLK;
  logic        RESET;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [31:0] jr_value;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] rc_val;
  logic [4:0]  write_reg;
  logic [31:0] next_addr;
  logic        link;
  logic        reg_dst;
  logic        jump;
  logic        branch;
  logic        mem_read;
  logic        mem_write;
  logic        alu_src;
  logic        reg_write;
  logic        jump_register;
  logic        sign_or_zero;
  logic        syscall;
  logic [5:0]  alu_control;

  int total = 0;
  int bad   = 0;

  // Flag bit positions: {link,reg_dst,jump,branch,mem_read,mem_write,
  //                      alu_src,reg_write,jump_register,sign_or_zero,syscall}
  localparam logic [10:0] LNK = 11'h400;
  localparam logic [10:0] RDS = 11'h200;
  localparam logic [10:0] JMP = 11'h100;
  localparam logic [10:0] BR  = 11'h080;
  localparam logic [10:0] MR  = 11'h040;
  localparam logic [10:0] MW  = 11'h020;
  localparam logic [10:0] AS  = 11'h010;
  localparam logic [10:0] RW  = 11'h008;
  localparam logic [10:0] JR  = 11'h004;
  localparam logic [10:0] SZ  = 11'h002;
  localparam logic [10:0] SC  = 11'h001;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] jrv;
    logic [10:0] flags;
    logic [4:0]  wreg;
    logic [31:0] naddr;
    logic [5:0]  aluc;
  } vec_t;

  vec_t vecs[$];

  mips_decode_unit dut (
    .CLK(CLK), .RESET(RESET), .instr(instr), .pc_plus4(pc_plus4),
    .jr_value(jr_value), .wb_reg(wb_reg), .wb_data(wb_data), .wb_en(wb_en),
    .rs_val(rs_val), .rt_val(rt_val), .rc_val(rc_val), .write_reg(write_reg),
    .next_addr(next_addr), .link(link), .reg_dst(reg_dst), .jump(jump),
    .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .jump_register(jump_register),
    .sign_or_zero(sign_or_zero), .syscall(syscall), .alu_control(alu_control)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] flags_now();
    return {link, reg_dst, jump, branch, mem_read, mem_write,
            alu_src, reg_write, jump_register, sign_or_zero, syscall};
  endfunction

  task automatic drive_decode(input logic [31:0] i, input logic [31:0] p, input logic [31:0] j);
    @(negedge CLK);
    instr    = i;
    pc_plus4 = p;
    jr_value = j;
    #2;
  endtask

  task automatic write_reg_file(input logic [4:0] r, input logic [31:0] d);
    @(negedge CLK);
    wb_reg  = r;
    wb_data = d;
    wb_en   = 1'b1;
    @(posedge CLK);
    #1;
    wb_en   = 1'b0;
  endtask

  initial begin
    RESET    = 1'b0;
    instr    = 32'h0;
    pc_plus4 = 32'h0;
    jr_value = 32'h0;
    wb_reg   = 5'd0;
    wb_data  = 32'h0;
    wb_en    = 1'b0;

    //          name        instr         pc4           jrv           flags                 wreg   naddr         aluc
    vecs.push_back('{"j",       32'h08000010, 32'h40000004, 32'h0,        JMP,                  5'd0,  32'h40000040, 6'h02});
    vecs.push_back('{"beq",     32'h1000FFFF, 32'h00000100, 32'h0,        BR|SZ,                5'd0,  32'h000000FC, 6'h04});
    vecs.push_back('{"jal",     32'h0C000000, 32'h00400004, 32'h0,        JMP|LNK|RW,           5'd31, 32'h00000000, 6'h03});
    vecs.push_back('{"syscall", 32'h0000000C, 32'h00000100, 32'h0,        SC,                   5'd0,  32'h00000130, 6'h0C});
    vecs.push_back('{"jr",      32'h03E00008, 32'h00000100, 32'h00000400, JMP|JR,               5'd0,  32'h00000400, 6'h08});
    vecs.push_back('{"ori",     32'h34628000, 32'h00001000, 32'h0,        AS|RW,                5'd2,  32'hFFFE1000, 6'h0D});
    vecs.push_back('{"add",     32'h00430820, 32'h00000200, 32'h0,        RDS|RW,               5'd1,  32'h00002280, 6'h20});
    vecs.push_back('{"jalr",    32'h0080F809, 32'h00000100, 32'h12345678, JMP|JR|LNK|RDS|RW,    5'd31, 32'h12345678, 6'h09});
    vecs.push_back('{"lw",      32'h8FA80004, 32'h00000100, 32'h0,        MR|AS|RW|SZ,          5'd8,  32'h00000110, 6'h23});
    vecs.push_back('{"sw",      32'hAFA8FFFC, 32'h00000100, 32'h0,        MW|AS|SZ,             5'd8,  32'h000000F0, 6'h2B});
    vecs.push_back('{"sc",      32'hE0890000, 32'h00000100, 32'h0,        MW|AS|SZ|RW,          5'd9,  32'h00000100, 6'h38});
    vecs.push_back('{"bgezal",  32'h04B10002, 32'h00000100, 32'h0,        BR|SZ|LNK|RW,         5'd31, 32'h00000108, 6'h01});
    vecs.push_back('{"bgez",    32'h04A10003, 32'h00000100, 32'h0,        BR|SZ,                5'd1,  32'h0000010C, 6'h01});
    vecs.push_back('{"rimm_bad",32'h04A50000, 32'h00000100, 32'h0,        11'h000,              5'd5,  32'h00000100, 6'h01});
    vecs.push_back('{"op_bad",  32'hFC000000, 32'h00000100, 32'h0,        11'h000,              5'd0,  32'h00000100, 6'h3F});
    vecs.push_back('{"fn_bad",  32'h00000001, 32'h00000100, 32'h0,        11'h000,              5'd0,  32'h00000104, 6'h01});
    vecs.push_back('{"lui",     32'h3C071234, 32'h00000000, 32'h0,        AS|RW,                5'd7,  32'h000048D0, 6'h0F});
    vecs.push_back('{"addi",    32'h2007FFFF, 32'h00000000, 32'h0,        AS|RW|SZ,             5'd7,  32'hFFFFFFFC, 6'h08});
    vecs.push_back('{"sll",     32'h00031100, 32'h00000000, 32'h0,        RDS|RW,               5'd2,  32'h00004400, 6'h00});
    vecs.push_back('{"bne",     32'h14000001, 32'h00000100, 32'h0,        BR|SZ,                5'd0,  32'h00000104, 6'h05});

    // Decode stays live while reset is held.
    drive_decode(32'h08000010, 32'h40000004, 32'h0);
    check("rst_decode_jump", {31'd0, jump}, 32'd1);
    check("rst_decode_addr", next_addr, 32'h40000040);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;

    // Reset state of register file.
    drive_decode(32'h00A63800, 32'h0, 32'h0);  // rs=5 rt=6 rd=7
    check("reset_rs5", rs_val, 32'h0);
    check("reset_rt6", rt_val, 32'h0);

    // Same-cycle read before the write edge returns the old value.
    @(negedge CLK);
    wb_reg  = 5'd5;
    wb_data = 32'hDEADBEEF;
    wb_en   = 1'b1;
    #2;
    check("pre_edge_rs5", rs_val, 32'h0);
    @(posedge CLK);
    #1;
    wb_en = 1'b0;
    check("post_edge_rs5", rs_val, 32'hDEADBEEF);

    // rt read port and rc read port (write_reg = rt for ori).
    write_reg_file(5'd6, 32'hCAFE0006);
    check("rt6", rt_val, 32'hCAFE0006);
    drive_decode(32'h34050001, 32'h0, 32'h0);  // ori $5,$0,1
    check("rc_wreg", {27'd0, write_reg}, 32'd5);
    check("rc5", rc_val, 32'hDEADBEEF);

    // Register 0 ignores writes.
    write_reg_file(5'd0, 32'h00001234);
    drive_decode(32'h00000000, 32'h0, 32'h0);
    check("r0_stays_zero", rs_val, 32'h0);

    // wb_en low blocks the write.
    @(negedge CLK);
    wb_reg  = 5'd5;
    wb_data = 32'h11111111;
    wb_en   = 1'b0;
    @(posedge CLK);
    #1;
    drive_decode(32'h00A00000, 32'h0, 32'h0);
    check("no_en_rs5", rs_val, 32'hDEADBEEF);

    // Asynchronous reset clears mid-cycle, and writes are ignored while low.
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check("async_clear_rs5", rs_val, 32'h0);
    @(negedge CLK);
    wb_reg  = 5'd5;
    wb_data = 32'h55555555;
    wb_en   = 1'b1;
    @(posedge CLK);
    #1;
    wb_en = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    check("write_in_reset", rs_val, 32'h0);

    // Table of decode vectors.
    foreach (vecs[k]) begin
      drive_decode(vecs[k].instr, vecs[k].pc4, vecs[k].jrv);
      check({vecs[k].name, "_flags"}, {21'd0, flags_now()}, {21'd0, vecs[k].flags});
      check({vecs[k].name, "_wreg"},  {27'd0, write_reg},   {27'd0, vecs[k].wreg});
      check({vecs[k].name, "_naddr"}, next_addr,            vecs[k].naddr);
      check({vecs[k].name, "_aluc"},  {26'd0, alu_control}, {26'd0, vecs[k].aluc});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
